// File: rtl/nios_blink_mem_loader.sv
// Byte-stream to 32-bit RAM loader.
// Packs an incoming byte stream little-endian into words and writes each word
// to the RAM slave. The processor is held off the memory while a load runs.
module nios_blink_mem_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 5120
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              cpu_reset_req,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              eop_q, eop_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    // Outputs decode directly from registered state, so none of them is combinational on inputs.
    assign in_ready       = (state_q == FILL);
    assign mem_chipselect = (state_q == WRITE);
    assign mem_write      = (state_q == WRITE);
    assign cpu_reset_req  = (state_q == FILL) || (state_q == WRITE);
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = data_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign words_written  = words_q;

    // Next-state logic: byte packing, word write sequencing and load termination.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        be_d    = be_q;
        data_d  = data_q;
        words_d = words_q;
        eop_d   = eop_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FILL;
                    addr_d  = '0;
                    lane_d  = 2'd0;
                    be_d    = 4'd0;
                    data_d  = 32'd0;
                    words_d = '0;
                    eop_d   = 1'b0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    case (lane_q)
                        2'd0:    data_d[7:0]   = in_data;
                        2'd1:    data_d[15:8]  = in_data;
                        2'd2:    data_d[23:16] = in_data;
                        default: data_d[31:24] = in_data;
                    endcase
                    be_d[lane_q] = 1'b1;
                    lane_d       = lane_q + 2'd1;
                    if (lane_q == 2'd3 || in_eop) begin
                        state_d = WRITE;
                        eop_d   = in_eop;
                    end
                end
            end
            WRITE: begin
                words_d = words_q + WORD_ONE;
                if (eop_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    // Image does not fit: stop and refuse the rest of the stream.
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = FILL;
                    addr_d  = addr_q + ADDR_ONE;
                    lane_d  = 2'd0;
                    be_d    = 4'd0;
                    data_d  = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous reset abandons any load in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lane_q  <= 2'd0;
            be_q    <= 4'd0;
            data_q  <= 32'd0;
            words_q <= '0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            be_q    <= be_d;
            data_q  <= data_d;
            words_q <= words_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
